// File: rtl/ibex_axi4l_bridge.sv
// Ibex data port (req/gnt/rvalid) to single-beat AXI4-Lite master.
// One outstanding access; window misses and stalled slaves return err.
module ibex_axi4l_bridge #(
    parameter int unsigned     AW      = 32,
    parameter int unsigned     DW      = 32,
    parameter int unsigned     SW      = 4,
    parameter logic [AW-1:0]   ADDR_LO = AW'('h4000),
    parameter logic [AW-1:0]   ADDR_HI = AW'('h40DF),
    parameter int unsigned     TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          data_req_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    input  logic          data_we_i,
    input  logic [SW-1:0] data_be_i,
    input  logic [AW-1:0] data_addr_i,
    input  logic [DW-1:0] data_wdata_i,
    output logic [DW-1:0] data_rdata_o,
    output logic          data_err_o,
    output logic [AW-1:0] awaddr_o,
    output logic          awvalid_o,
    input  logic          awready_i,
    output logic [DW-1:0] wdata_o,
    output logic [SW-1:0] wstrb_o,
    output logic          wvalid_o,
    input  logic          wready_i,
    input  logic          bvalid_i,
    input  logic [1:0]    bresp_i,
    output logic          bready_o,
    output logic [AW-1:0] araddr_o,
    output logic          arvalid_o,
    input  logic          arready_i,
    input  logic          rvalid_i,
    input  logic [1:0]    rresp_i,
    input  logic [DW-1:0] rdata_i,
    output logic          rready_o
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    state_t        state;
    logic [31:0]   cnt;
    logic          aw_done;
    logic          w_done;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] be_q;

    logic [AW-1:0] addr_al;
    logic          in_win;
    logic          aw_fin;
    logic          w_fin;
    logic          tmo;

    assign addr_al  = {data_addr_i[AW-1:2], 2'b00};
    assign in_win   = (addr_al >= ADDR_LO) && (addr_al <= ADDR_HI);
    assign aw_fin   = aw_done | (awvalid_o & awready_i);
    assign w_fin    = w_done | (wvalid_o & wready_i);
    // Counter reaching TIMEOUT on this wait cycle aborts at the next edge.
    assign tmo      = (TIMEOUT != 0) && (cnt == TIMEOUT - 1);

    assign data_gnt_o = rst_ni & data_req_i & (state == IDLE);
    assign awaddr_o   = addr_q;
    assign araddr_o   = addr_q;
    assign wdata_o    = wdata_q;
    assign wstrb_o    = be_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            cnt           <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            awvalid_o     <= 1'b0;
            wvalid_o      <= 1'b0;
            bready_o      <= 1'b0;
            arvalid_o     <= 1'b0;
            rready_o      <= 1'b0;
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
            data_err_o    <= 1'b0;
        end else begin
            data_rvalid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (data_gnt_o) begin
                        addr_q  <= addr_al;
                        wdata_q <= data_wdata_i;
                        be_q    <= data_be_i;
                        cnt     <= '0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (!in_win) begin
                            state         <= RESP;
                            data_rvalid_o <= 1'b1;
                            data_err_o    <= 1'b1;
                            data_rdata_o  <= '0;
                        end else if (data_we_i) begin
                            state     <= WR_ADDR_DATA;
                            awvalid_o <= 1'b1;
                            wvalid_o  <= 1'b1;
                        end else begin
                            state     <= RD_ADDR;
                            arvalid_o <= 1'b1;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    aw_done <= aw_fin;
                    w_done  <= w_fin;
                    if (awvalid_o && awready_i) awvalid_o <= 1'b0;
                    if (wvalid_o && wready_i) wvalid_o <= 1'b0;
                    if (aw_fin && w_fin) begin
                        state    <= WR_RESP;
                        bready_o <= 1'b1;
                        cnt      <= '0;
                    end else if (tmo) begin
                        awvalid_o     <= 1'b0;
                        wvalid_o      <= 1'b0;
                        state         <= RESP;
                        data_rvalid_o <= 1'b1;
                        data_err_o    <= 1'b1;
                        data_rdata_o  <= '0;
                    end else begin
                        cnt <= cnt + 1;
                    end
                end
                WR_RESP: begin
                    if (bvalid_i || tmo) begin
                        bready_o      <= 1'b0;
                        state         <= RESP;
                        data_rvalid_o <= 1'b1;
                        data_err_o    <= bvalid_i ? bresp_i[1] : 1'b1;
                        data_rdata_o  <= '0;
                    end else begin
                        cnt <= cnt + 1;
                    end
                end
                RD_ADDR: begin
                    if (arready_i) begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                        state     <= RD_DATA;
                        cnt       <= '0;
                    end else if (tmo) begin
                        arvalid_o     <= 1'b0;
                        state         <= RESP;
                        data_rvalid_o <= 1'b1;
                        data_err_o    <= 1'b1;
                        data_rdata_o  <= '0;
                    end else begin
                        cnt <= cnt + 1;
                    end
                end
                RD_DATA: begin
                    if (rvalid_i || tmo) begin
                        rready_o      <= 1'b0;
                        state         <= RESP;
                        data_rvalid_o <= 1'b1;
                        data_err_o    <= rvalid_i ? rresp_i[1] : 1'b1;
                        data_rdata_o  <= rvalid_i ? rdata_i : '0;
                    end else begin
                        cnt <= cnt + 1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_axi4l_bridge.sv
// Directed + random bench for ibex_axi4l_bridge with a bench-side slave
// and a transaction-level model of latency, response and memory.
module tb_ibex_axi4l_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_req = 1'b0;
    logic        data_gnt;
    logic        data_rvalid;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_err;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic        bvalid = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic        rvalid = 1'b0;
    logic [1:0]  rresp = '0;
    logic [31:0] rdata = '0;
    logic        rready;

    always #5 clk = ~clk;

    ibex_axi4l_bridge #(.TIMEOUT(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .data_req_i(data_req), .data_gnt_o(data_gnt),
        .data_rvalid_o(data_rvalid), .data_we_i(data_we),
        .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rdata_o(data_rdata),
        .data_err_o(data_err),
        .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
        .wdata_o(wdata), .wstrb_o(wstrb), .wvalid_o(wvalid),
        .wready_i(wready),
        .bvalid_i(bvalid), .bresp_i(bresp), .bready_o(bready),
        .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
        .rvalid_i(rvalid), .rresp_i(rresp), .rdata_i(rdata),
        .rready_o(rready)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] smem [0:55];
    logic [31:0] ref_mem [0:55];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sidx(input logic [31:0] a);
        logic [31:0] o;
        o = (a - 32'h4000) >> 2;
        return (o > 55) ? 0 : int'(o);
    endfunction

    // a_d: wait before awready/arready, w_d: before wready, r_d: before b/r valid
    task automatic txn(input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd,
                       input int a_d, input int w_d, input int r_d,
                       input logic [1:0] resp, input string tag);
        logic [31:0] al, e_rd, rd;
        logic        inwin, e_err, err, done;
        int          idx, stall, e_lat, e_aw, e_w, e_ar, lat;
        int          n_aw, n_w, n_ar, aw_c, w_c, ar_c, b_c, r_c;
        al    = addr & 32'hFFFF_FFFC;
        inwin = (al >= 32'h4000) && (al <= 32'h40DF);
        idx   = inwin ? sidx(al) : 0;
        e_rd = '0; e_err = 1'b1; e_lat = 1; e_aw = 0; e_w = 0; e_ar = 0;
        if (inwin && we) begin
            stall = (a_d > w_d) ? a_d : w_d;
            if (stall >= 8) begin
                e_aw = (a_d + 1 > 8) ? 8 : a_d + 1;
                e_w  = (w_d + 1 > 8) ? 8 : w_d + 1;
                e_lat = 9;
            end else begin
                e_aw = a_d + 1; e_w = w_d + 1;
                e_lat = 3 + stall + r_d;
                e_err = (resp >= 2);
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
            end
        end else if (inwin) begin
            if (a_d >= 8) begin
                e_ar = 8; e_lat = 9;
            end else begin
                e_ar = a_d + 1;
                e_lat = 3 + a_d + r_d;
                e_rd = ref_mem[idx];
                e_err = (resp >= 2);
            end
        end

        @(negedge clk);
        data_req = 1'b1; data_we = we; data_addr = addr;
        data_be = be; data_wdata = wd;
        #1 chk({tag, ".gnt"}, data_gnt, 1);
        done = 0; lat = 0; rd = 'x; err = 'x;
        n_aw = 0; n_w = 0; n_ar = 0;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            data_req = 1'b0;
            if (data_rvalid) begin
                done = 1; lat = c; rd = data_rdata; err = data_err;
            end else begin
                if (awvalid) begin
                    n_aw++;
                    chk({tag, ".awaddr"}, awaddr, al);
                    awready = (aw_c >= a_d); aw_c++;
                end else awready = 1'b0;
                if (wvalid) begin
                    n_w++;
                    chk({tag, ".wdata"}, wdata, wd);
                    chk({tag, ".wstrb"}, wstrb, be);
                    wready = (w_c >= w_d); w_c++;
                end else wready = 1'b0;
                if (arvalid) begin
                    n_ar++;
                    chk({tag, ".araddr"}, araddr, al);
                    arready = (ar_c >= a_d); ar_c++;
                end else arready = 1'b0;
                if (bready && b_c >= r_d) begin
                    bvalid = 1'b1; bresp = resp;
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) smem[sidx(awaddr)][8*b +: 8] = wdata[8*b +: 8];
                end else begin
                    bvalid = 1'b0;
                    if (bready) b_c++;
                end
                if (rready && r_c >= r_d) begin
                    rvalid = 1'b1; rresp = resp; rdata = smem[sidx(araddr)];
                end else begin
                    rvalid = 1'b0;
                    if (rready) r_c++;
                end
            end
        end
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        chk({tag, ".lat"}, lat, e_lat);
        chk({tag, ".rdata"}, rd, e_rd);
        chk({tag, ".err"}, err, e_err);
        chk({tag, ".aw_cycles"}, n_aw, e_aw);
        chk({tag, ".w_cycles"}, n_w, e_w);
        chk({tag, ".ar_cycles"}, n_ar, e_ar);
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 56; i++) begin
            v = $urandom;
            smem[i] = v;
            ref_mem[i] = v;
        end
        smem[4] = 32'hA5A5_0001;
        ref_mem[4] = 32'hA5A5_0001;

        data_req = 1'b1;
        #12;
        chk("rst.gnt", data_gnt, 0);
        chk("rst.rvalid", data_rvalid, 0);
        chk("rst.awvalid", awvalid, 0);
        chk("rst.wvalid", wvalid, 0);
        chk("rst.arvalid", arvalid, 0);
        chk("rst.bready", bready, 0);
        chk("rst.rready", rready, 0);
        chk("rst.awaddr", awaddr, 0);
        chk("rst.rdata", data_rdata, 0);
        chk("rst.err", data_err, 0);
        data_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        txn(0, 32'h4010, 4'hF, 0, 0, 0, 0, 2'b00, "rd4010");
        txn(1, 32'h400C, 4'b0011, 32'h1234_5678, 2, 0, 0, 2'b00, "wr400C");
        txn(0, 32'h400C, 4'hF, 0, 0, 0, 1, 2'b01, "rb400C");
        txn(1, 32'h3000, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 2'b00, "wr3000");
        txn(0, 32'h4080, 4'hF, 0, 1, 0, 1, 2'b10, "rd4080");
        txn(0, 32'h40DF, 4'hF, 0, 0, 0, 0, 2'b11, "rd40DF");
        txn(0, 32'h40E0, 4'hF, 0, 0, 0, 0, 2'b00, "rd40E0");
        txn(0, 32'h3FFC, 4'hF, 0, 0, 0, 0, 2'b00, "rd3FFC");
        txn(0, 32'h4020, 4'hF, 0, 100, 0, 0, 2'b00, "rdtmo");
        txn(1, 32'h4024, 4'hF, 32'h0BAD_F00D, 0, 100, 0, 2'b00, "wrtmo");
        txn(1, 32'h4000, 4'b1100, 32'hCAFE_0000, 0, 3, 2, 2'b00, "wr4000");

        @(negedge clk);
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h4004;
        data_be = 4'hF; data_wdata = 32'h5555_AAAA;
        #1 chk("mid.gnt", data_gnt, 1);
        @(negedge clk);
        data_req = 1'b0; awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        chk("mid.bready", bready, 1);
        rst_n = 1'b0;
        #1;
        chk("mid.rst_bready", bready, 0);
        chk("mid.rst_awvalid", awvalid, 0);
        chk("mid.rst_wvalid", wvalid, 0);
        chk("mid.rst_arvalid", arvalid, 0);
        chk("mid.rst_rready", rready, 0);
        chk("mid.rst_rvalid", data_rvalid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid.no_rvalid", data_rvalid, 0);
            if (i == 1) rst_n = 1'b1;
        end
        txn(0, 32'h4004, 4'hF, 0, 0, 0, 0, 2'b00, "rd_after_rst");

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'h4000 + $urandom_range(0, 55) * 4 + $urandom_range(0, 3);
            txn(1'($urandom_range(0, 1)), a, 4'($urandom_range(1, 15)),
                $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 4), 2'($urandom_range(0, 3)),
                $sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ibex_axi4l_bridge.md
Name: ibex_axi4l_bridge

Overview:
Converts the Ibex core data-memory port (req/gnt/rvalid protocol) into single-beat AXI4-Lite master transactions toward the peripheral slaves (IO module, UART0, Timer, Timer1). Sits between the CPU data port and the peripheral bus. Allows one outstanding transaction at a time. Out-of-window addresses and stalled slaves are returned to the core as errors.

Parameters:
AW, 32, address width
DW, 32, data width
SW, 4, byte-strobe width (DW/8)
ADDR_LO, 32'h4000, lowest address forwarded to AXI (inclusive)
ADDR_HI, 32'h40DF, highest address forwarded to AXI (inclusive)
TIMEOUT, 255, max cycles spent in any AXI wait state before an error abort; 0 disables the timeout

Ports:
clk_i  in  1  system clock, rising edge
rst_ni  in  1  asynchronous active-low reset
data_req_i  in  1  core request
data_gnt_o  out  1  request accepted
data_rvalid_o  out  1  response valid, one-cycle pulse
data_we_i  in  1  1 = write
data_be_i  in  SW  byte enables
data_addr_i  in  AW  byte address
data_wdata_i  in  DW  write data
data_rdata_o  out  DW  read data
data_err_o  out  1  error, valid with data_rvalid_o
awaddr_o, awvalid_o / awready_i  out,out/in  AW,1/1  write-address channel
wdata_o, wstrb_o, wvalid_o / wready_i  out,out,out/in  DW,SW,1/1  write-data channel
bvalid_i, bresp_i / bready_o  in,in/out  1,2/1  write-response channel
araddr_o, arvalid_o / arready_i  out,out/in  AW,1/1  read-address channel
rvalid_i, rresp_i, rdata_i / rready_o  in,in,in/out  1,2,DW/1  read-data channel

Behaviour:
- Reset: all outputs 0. State = IDLE. Latched address, data, strobe and timeout counter cleared.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: data_gnt_o = data_req_i (combinational). On gnt, latch addr (bits [1:0] forced to 0), wdata, be and we.
  - Address outside [ADDR_LO, ADDR_HI] -> go to RESP with err=1, rdata=0. No AXI activity.
  - Write -> go to WR_ADDR_DATA. Read -> go to RD_ADDR.
- data_gnt_o is 0 in every state except IDLE. The core's next request waits until the bridge is back in IDLE.
- WR_ADDR_DATA:
  - awvalid_o and wvalid_o rise together on the cycle after gnt.
  - Each valid drops on the cycle after its own ready is seen high. The two handshakes may complete in either order or together.
  - Once both are done, go to WR_RESP.
  - wstrb_o = latched be; awaddr_o/wdata_o stay stable while the corresponding valid is high.
- WR_RESP: bready_o=1. On bvalid_i, capture err = bresp_i[1] and go to RESP.
- RD_ADDR: arvalid_o=1 until arready_i, then go to RD_DATA.
- RD_DATA: rready_o=1. On rvalid_i, capture rdata_i and err = rresp_i[1], then go to RESP.
- RESP: data_rvalid_o=1 for exactly one cycle, with data_rdata_o/data_err_o valid. Writes return rdata=0. Next state IDLE.
- Minimum latency with zero-wait slaves:
  - read: gnt cycle 0, arvalid cycle 1, rvalid_i cycle 2, data_rvalid_o cycle 3.
  - write: same shape, with bvalid_i at cycle 2.
- Timeout:
  - Counter clears on entry to each AXI state and increments each cycle spent waiting.
  - When it reaches TIMEOUT (TIMEOUT != 0), all AXI valids/readys drop next cycle, state goes to RESP with err=1.
  - The abort is a known AXI rule violation, accepted for the local bus.
- Outputs data_rdata_o/data_err_o hold their last value outside RESP; checks only apply when data_rvalid_o is high.
- Reset asserted mid-transaction: immediate return to IDLE, all valids/readys 0, no response pulse.
- bresp/rresp 2'b10 and 2'b11 both map to err=1; 2'b00 and 2'b01 map to err=0.

Test Plan:
- Read 0x4010, arready=1 and rvalid_i=1 with rdata 32'hA5A5_0001 one cycle later -> data_rvalid_o at cycle 3, rdata 32'hA5A5_0001, err 0.
- Write 0x400C, be=4'b0011, wdata 32'h1234_5678; wready 2 cycles before awready; bresp 00 -> wvalid_o drops first, awvalid_o drops later; wstrb 0011; err 0.
- Write 0x3000 (outside window) -> gnt, no AXI valids, data_rvalid_o next cycle with err 1, rdata 0.
- Read 0x4080 with rresp=2'b10 -> err 1 and rdata passed through.
- TIMEOUT=8, arready held 0 -> arvalid_o drops after 8 cycles, err 1 pulse, next request granted.
- Reset pulse during WR_RESP -> all outputs 0, no data_rvalid_o; a new read after reset completes normally.
